pipelined_alu: RTL and testbench
================================

// Module: pipelined_alu
// PURPOSE
//  Parametrised, handshaked successor to the 32-bit combinational ALU. Executes ADD/SUB/AND/OR/SLL/SRA
//  in a single registered cycle, plus iterative signed MULT and DIV, with flags and a registered output.
//  Sits in the execute stage; valid/ready on both sides lets the pipeline stall on multicycle ops.
// PARAMETERS
//  WIDTH    32               operand/result width in bits (>=8, power of 2)
//  SHAMT_W  $clog2(WIDTH)    shift-amount width
// PORTS
//  clock           in   1        rising-edge clock; the only clock
//  reset_n         in   1        asynchronous, active-low reset
//  flush           in   1        synchronous abort of in-flight op and pending result
//  in_valid        in   1        operands/opcode valid
//  in_ready        out  1        block can accept this cycle
//  ctrl_ALUopcode  in   5        operation select (encoding below)
//  ctrl_shiftamt   in   SHAMT_W  shift amount for SLL/SRA
//  data_operandA   in   WIDTH    operand A
//  data_operandB   in   WIDTH    operand B
//  out_valid       out  1        result/flags valid
//  out_ready       in   1        consumer accepts result
//  data_result     out  WIDTH    result
//  isNotEqual      out  1        A!=B (SUB only, else 0)
//  isLessThan      out  1        signed A<B (SUB only, else 0)
//  overflow        out  1        signed overflow (ADD/SUB/MULT/DIV)
//  exception       out  1        DIV by zero or illegal opcode
// BEHAVIOUR
//  Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA, 6 MULT, 7 DIV; 8..31 illegal.
//  Reset (async, reset_n=0): state=IDLE, out_valid=0, data_result=0, all flags 0, in_ready=0 while asserted.
//  Accept: in_valid & in_ready at rising edge. in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
//  FSM: IDLE -> (simple op) IDLE with out_valid=1 at same edge; IDLE -> MUL/DIV (iterative) -> DONE -> IDLE.
//   - Simple ops: result registered on accept edge; back-to-back throughput 1/cycle if out_ready=1.
//   - MUL/DIV: exactly WIDTH iteration cycles after accept, then DONE loads outputs; out_valid rises
//     WIDTH+1 edges after accept. in_ready=0 throughout MUL/DIV/DONE.
//  Output hold: result and flags stable while out_valid & !out_ready; cleared to 0 only when the next op
//   loads. out_valid drops on out_ready edge unless a new simple op is accepted in the same cycle.
//  Arithmetic (two's complement, WIDTH bits):
//   ADD/SUB: overflow = sign(A)==sign(B') & sign(R)!=sign(A), B'=B or ~B+1. SUB: isNotEqual=(A!=B);
//    isLessThan = R[MSB]^overflow (correct across overflow). A=B=0 SUB -> R=0, all flags 0.
//   AND/OR bitwise; SLL zero-fill; SRA sign-fill; shift by 0 returns A. No flags.
//   MULT: signed, result = low WIDTH bits of 2*WIDTH product; overflow=1 iff high half != sign-extension.
//   DIV: signed, truncate toward zero. B=0 -> R=0, exception=1, no iterations (out_valid next edge).
//    A=-2^(WIDTH-1), B=-1 -> R=-2^(WIDTH-1), overflow=1. Remainder not output.
//   Illegal opcode: R=0, exception=1, 1-cycle latency.
//  Boundaries: flush=1 at an edge -> state=IDLE, out_valid=0, iteration counter cleared; flush wins over
//   a simultaneous accept (nothing accepted). Reset mid-MUL/DIV aborts with no output. in_valid while
//   busy is ignored (not buffered); producer must hold. Iteration counter is SHAMT_W+1 bits, no wrap.
// TESTING (WIDTH=32)
//  1. ADD 0x7FFFFFFF+1, out_ready=1 -> next edge R=0x80000000, overflow=1, isLessThan=0, exception=0.
//  2. SUB A=-5 B=3 -> R=0xFFFFFFF8, isNotEqual=1, isLessThan=1; SUB 0x80000000-1 -> overflow=1, isLessThan=1.
//  3. MULT 0x00010000*0x00010000 -> out_valid 33 edges after accept, R=0, overflow=1; MULT -7*6 -> R=-42, ovf=0.
//  4. DIV -7/2 -> R=-3 after 33 edges; DIV 5/0 -> R=0, exception=1 one edge later; 0x80000000/-1 -> ovf=1.
//  5. Back-to-back AND,OR,SLL(A=1,sh=31),SRA(A=0x80000000,sh=4) with out_ready=1 -> one result/cycle:
//     ..., 0x80000000, 0xF8000000; hold out_ready=0 for 3 cycles -> result/flags frozen, in_ready=0.
//  6. Start DIV, flush at iteration 10 -> out_valid stays 0, in_ready=1 next cycle; repeat with reset_n=0
//     mid-MULT -> all outputs 0 immediately, clean ADD 2+2=4 after release.

Source files
------------

// File: rtl/pipelined_alu.sv
// Execute-stage ALU with valid/ready handshakes: single-cycle simple ops plus
// iterative signed multiply and divide, with flags held until the consumer accepts.
//
// state   | meaning
// Idle    | ready for a new op; simple ops complete here on the accept edge
// MulBusy | shift-add multiply on operand magnitudes, WIDTH iterations
// DivBusy | restoring divide on operand magnitudes, WIDTH iterations
// Done    | apply result sign, load outputs, return to Idle
module pipelined_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         ctrl_ALUopcode,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [WIDTH-1:0]   data_operandB,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_result,
    output logic               isNotEqual,
    output logic               isLessThan,
    output logic               overflow,
    output logic               exception
);

    localparam logic [4:0] OpAdd  = 5'd0;
    localparam logic [4:0] OpSub  = 5'd1;
    localparam logic [4:0] OpAnd  = 5'd2;
    localparam logic [4:0] OpOr   = 5'd3;
    localparam logic [4:0] OpSll  = 5'd4;
    localparam logic [4:0] OpSra  = 5'd5;
    localparam logic [4:0] OpMult = 5'd6;
    localparam logic [4:0] OpDiv  = 5'd7;

    localparam int                 MSB    = WIDTH - 1;
    localparam logic [WIDTH-1:0]   MinInt = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHAMT_W:0]   IterLoad = (SHAMT_W+1)'(WIDTH);
    localparam logic [SHAMT_W:0]   IterOne  = (SHAMT_W+1)'(1);

    typedef enum logic [1:0] {Idle, MulBusy, DivBusy, Done} aluStateT;

    aluStateT state, nextState;

    logic accept, isMultOp, isDivOp, divByZero, startIter, loadSimple, loadDone, iterLast;

    logic [WIDTH-1:0] absA, absB;
    logic [WIDTH-1:0] sumAB, diffAB;
    logic [WIDTH-1:0] simpleResult;
    logic             simpleNe, simpleLt, simpleOvf, simpleExc;

    logic [SHAMT_W:0]   iterCnt;
    logic [2*WIDTH-1:0] mulAcc, mulMcand, mulProd;
    logic [WIDTH-1:0]   mulMplier;
    logic [WIDTH-1:0]   divRem, divQuo, divDivisor, divFinal;
    logic [WIDTH:0]     remShift, remSub;
    logic               negResult, divOvf, opIsDiv, mulOvf;

    assign in_ready   = reset_n & (state == Idle) & (~out_valid | out_ready) & ~flush;
    assign accept     = in_valid & in_ready;
    assign isMultOp   = (ctrl_ALUopcode == OpMult);
    assign isDivOp    = (ctrl_ALUopcode == OpDiv);
    assign divByZero  = isDivOp & (data_operandB == '0);
    assign startIter  = accept & (isMultOp | (isDivOp & ~divByZero));
    assign loadSimple = accept & ~startIter;
    assign loadDone   = (state == Done);
    assign iterLast   = (iterCnt == IterOne);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= Idle;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            Idle:             if (startIter) nextState = isMultOp ? MulBusy : DivBusy;
            MulBusy, DivBusy: if (iterLast)  nextState = Done;
            Done:             nextState = Idle;
            default:          nextState = Idle;
        endcase
        if (flush) nextState = Idle;
    end

    // Single-cycle ops; divide-by-zero and illegal opcodes also resolve here.
    always_comb begin
        simpleResult = '0;
        simpleNe     = 1'b0;
        simpleLt     = 1'b0;
        simpleOvf    = 1'b0;
        simpleExc    = 1'b0;
        sumAB        = data_operandA + data_operandB;
        diffAB       = data_operandA - data_operandB;
        case (ctrl_ALUopcode)
            OpAdd: begin
                simpleResult = sumAB;
                simpleOvf    = (data_operandA[MSB] == data_operandB[MSB]) & (sumAB[MSB] != data_operandA[MSB]);
            end
            OpSub: begin
                simpleResult = diffAB;
                simpleOvf    = (data_operandA[MSB] != data_operandB[MSB]) & (diffAB[MSB] != data_operandA[MSB]);
                simpleNe     = (data_operandA != data_operandB);
                simpleLt     = diffAB[MSB] ^ simpleOvf;
            end
            OpAnd:  simpleResult = data_operandA & data_operandB;
            OpOr:   simpleResult = data_operandA | data_operandB;
            OpSll:  simpleResult = data_operandA << ctrl_shiftamt;
            OpSra:  simpleResult = WIDTH'($signed(data_operandA) >>> ctrl_shiftamt);
            OpMult: simpleExc    = 1'b0;
            OpDiv:  simpleExc    = divByZero;
            default: simpleExc   = 1'b1;
        endcase
    end

    assign absA = data_operandA[MSB] ? -data_operandA : data_operandA;
    assign absB = data_operandB[MSB] ? -data_operandB : data_operandB;

    assign remShift = {divRem, divQuo[MSB]};
    assign remSub   = remShift - {1'b0, divDivisor};

    // Iterations run on magnitudes; the sign is restored once in Done.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iterCnt    <= '0;
            mulAcc     <= '0;
            mulMcand   <= '0;
            mulMplier  <= '0;
            divRem     <= '0;
            divQuo     <= '0;
            divDivisor <= '0;
            negResult  <= 1'b0;
            divOvf     <= 1'b0;
            opIsDiv    <= 1'b0;
        end else if (flush) begin
            iterCnt <= '0;
        end else if (startIter) begin
            iterCnt    <= IterLoad;
            mulAcc     <= '0;
            mulMcand   <= {{WIDTH{1'b0}}, absA};
            mulMplier  <= absB;
            divRem     <= '0;
            divQuo     <= absA;
            divDivisor <= absB;
            negResult  <= data_operandA[MSB] ^ data_operandB[MSB];
            divOvf     <= isDivOp & (data_operandA == MinInt) & (data_operandB == '1);
            opIsDiv    <= isDivOp;
        end else if (state == MulBusy) begin
            iterCnt   <= iterCnt - IterOne;
            if (mulMplier[0]) mulAcc <= mulAcc + mulMcand;
            mulMcand  <= mulMcand << 1;
            mulMplier <= mulMplier >> 1;
        end else if (state == DivBusy) begin
            iterCnt <= iterCnt - IterOne;
            if (!remSub[WIDTH]) begin
                divRem <= remSub[WIDTH-1:0];
                divQuo <= {divQuo[WIDTH-2:0], 1'b1};
            end else begin
                divRem <= remShift[WIDTH-1:0];
                divQuo <= {divQuo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign mulProd  = negResult ? -mulAcc : mulAcc;
    assign mulOvf   = (mulProd[2*WIDTH-1:WIDTH] != {WIDTH{mulProd[MSB]}});
    assign divFinal = negResult ? -divQuo : divQuo;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            data_result <= '0;
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= 1'b0;
            exception   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (loadSimple) begin
            out_valid   <= 1'b1;
            data_result <= simpleResult;
            isNotEqual  <= simpleNe;
            isLessThan  <= simpleLt;
            overflow    <= simpleOvf;
            exception   <= simpleExc;
        end else if (loadDone) begin
            out_valid   <= 1'b1;
            data_result <= opIsDiv ? divFinal : mulProd[WIDTH-1:0];
            isNotEqual  <= 1'b0;
            isLessThan  <= 1'b0;
            overflow    <= opIsDiv ? divOvf : mulOvf;
            exception   <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipelined_alu.sv
// Scoreboard bench for pipelined_alu: a longint reference model queues expected
// results at accept time; a monitor pops and compares whenever a new result appears.
module tb_pipelined_alu;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]    ctrl_ALUopcode;
    logic [4:0]    ctrl_shiftamt;
    logic [W-1:0]  data_operandA, data_operandB, data_result;
    logic          isNotEqual, isLessThan, overflow, exception;

    pipelined_alu #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .exception      (exception)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  flags;
        int          lat;
        int          acceptEdge;
    } expT;

    expT expQ[$];
    int  nChecks = 0;
    int  nFail   = 0;
    int  cycleCnt = 0;
    bit  randReady = 0;
    bit  prevValid = 0;
    bit  prevReady = 0;

    always @(posedge clock) cycleCnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain signed 64-bit arithmetic on the operands.
    function automatic expT model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh);
        expT    e;
        longint sa, sb, full;
        longint maxI, minI;
        logic   ne, lt, ovf, exc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        maxI = 64'sd2147483647;
        minI = -64'sd2147483648;
        ne = 0; lt = 0; ovf = 0; exc = 0;
        e.result = '0; e.lat = 0; e.acceptEdge = 0;
        case (op)
            5'd0: begin full = sa + sb; e.result = full[31:0]; ovf = (full > maxI) || (full < minI); end
            5'd1: begin
                full = sa - sb; e.result = full[31:0]; ovf = (full > maxI) || (full < minI);
                ne = (a != b); lt = (sa < sb);
            end
            5'd2: e.result = a & b;
            5'd3: e.result = a | b;
            5'd4: e.result = a << sh;
            5'd5: begin full = sa >>> sh; e.result = full[31:0]; end
            5'd6: begin
                full = sa * sb; e.result = full[31:0];
                ovf = (full != longint'($signed(full[31:0])));
                e.lat = W + 1;
            end
            5'd7: begin
                if (b == 0) exc = 1;
                else begin
                    e.lat = W + 1;
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.result = a; ovf = 1;
                    end else begin
                        full = sa / sb; e.result = full[31:0];
                    end
                end
            end
            default: exc = 1;
        endcase
        e.flags = {ne, lt, ovf, exc};
        return e;
    endfunction

    // A result is new when out_valid is seen and the previous one (if any) was taken.
    always @(negedge clock) begin
        expT e;
        if (!reset_n) begin
            prevValid = 0;
            prevReady = 0;
        end else begin
            if (out_valid && (!prevValid || prevReady)) begin
                if (expQ.size() == 0) begin
                    check("unexpected_output", {32'd0, data_result}, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = expQ.pop_front();
                    check("result", {32'd0, data_result}, {32'd0, e.result});
                    check("flags_ne_lt_ovf_exc", {60'd0, isNotEqual, isLessThan, overflow, exception},
                          {60'd0, e.flags});
                    check("latency", 64'(cycleCnt - e.acceptEdge), 64'(e.lat));
                end
            end
            prevValid = out_valid;
            prevReady = out_ready;
        end
    end

    task automatic stepCycle();
        @(posedge clock);
        #1;
        if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) stepCycle();
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit push, output int ae);
        expT e;
        bit  accepted;
        e = model(op, a, b, sh);
        ctrl_ALUopcode = op;
        data_operandA  = a;
        data_operandB  = b;
        ctrl_shiftamt  = sh;
        in_valid       = 1;
        accepted       = 0;
        ae             = -1;
        for (int n = 0; n < 150 && !accepted; n++) begin
            @(negedge clock);
            if (in_ready) begin
                accepted     = 1;
                ae           = cycleCnt + 1;
                e.acceptEdge = ae;
                if (push) expQ.push_back(e);
            end
            stepCycle();
        end
        in_valid = 0;
        check("accept_timeout", {63'd0, accepted}, 64'd1);
    endtask

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ae, aeFirst, aeLast, r;
        bit          sawValid;
        logic [4:0]  op, sh;
        logic [31:0] a, b;

        reset_n = 0; flush = 0; in_valid = 0; out_ready = 1;
        ctrl_ALUopcode = 0; ctrl_shiftamt = 0; data_operandA = 0; data_operandB = 0;
        repeat (2) @(negedge clock);
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_result", {32'd0, data_result}, 64'd0);
        check("reset_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd0);
        reset_n = 1;
        stepCycle();

        issue(5'd0, 32'h7FFF_FFFF, 32'h1, 0, 1, ae);
        issue(5'd1, 32'hFFFF_FFFB, 32'h3, 0, 1, ae);
        issue(5'd1, 32'h8000_0000, 32'h1, 0, 1, ae);
        issue(5'd1, 32'h0, 32'h0, 0, 1, ae);
        issue(5'd6, 32'h0001_0000, 32'h0001_0000, 0, 1, ae);
        issue(5'd6, 32'hFFFF_FFF9, 32'h6, 0, 1, ae);
        issue(5'd7, 32'hFFFF_FFF9, 32'h2, 0, 1, ae);
        issue(5'd7, 32'h5, 32'h0, 0, 1, ae);
        issue(5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, ae);
        issue(5'd9, 32'h1, 32'h2, 0, 1, ae);
        issue(5'd31, 32'h1234, 32'h5678, 0, 1, ae);
        issue(5'd4, 32'hA5A5_0001, 32'h0, 0, 1, ae);
        issue(5'd5, 32'h8000_00F0, 32'h0, 0, 1, ae);

        issue(5'd2, 32'hF0F0_FF00, 32'h0FF0_F0F0, 0, 1, aeFirst);
        issue(5'd3, 32'hF0F0_0000, 32'h0000_0F0F, 0, 1, ae);
        issue(5'd4, 32'h1, 32'h0, 5'd31, 1, ae);
        issue(5'd5, 32'h8000_0000, 32'h0, 5'd4, 1, aeLast);
        check("b2b_throughput_edges", 64'(aeLast - aeFirst), 64'd3);
        idle(3);

        out_ready = 0;
        issue(5'd0, 32'd10, 32'd20, 0, 1, ae);
        ctrl_ALUopcode = 5'd3; data_operandA = 32'h1; data_operandB = 32'h2; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_result", {32'd0, data_result}, 64'd30);
            check("hold_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'd0);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            stepCycle();
        end
        in_valid = 0;
        out_ready = 1;
        idle(3);

        issue(5'd7, 32'd100, 32'd7, 0, 0, ae);
        idle(9);
        flush = 1;
        stepCycle();
        flush = 0;
        @(negedge clock);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        sawValid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (out_valid) sawValid = 1;
        end
        check("flush_no_output", {63'd0, sawValid}, 64'd0);
        stepCycle();

        ctrl_ALUopcode = 5'd0; data_operandA = 32'd9; data_operandB = 32'd9;
        in_valid = 1; flush = 1;
        @(negedge clock);
        check("flush_blocks_ready", {63'd0, in_ready}, 64'd0);
        stepCycle();
        flush = 0; in_valid = 0;
        @(negedge clock);
        check("flush_wins_accept", {63'd0, out_valid}, 64'd0);
        stepCycle();

        issue(5'd0, 32'd2, 32'd3, 0, 1, ae);
        idle(2);
        issue(5'd6, 32'd3, 32'd5, 0, 0, ae);
        idle(5);
        reset_n = 0;
        #1;
        check("rst_mid_mult_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_mult_result", {32'd0, data_result}, 64'd0);
        check("rst_mid_mult_flags", {60'd0, isNotEqual, isLessThan, overflow, exception}, 64'd0);
        check("rst_mid_mult_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clock);
        reset_n = 1;
        stepCycle();
        issue(5'd0, 32'd2, 32'd2, 0, 1, ae);
        idle(2);

        randReady = 1;
        for (int i = 0; i < 150; i++) begin
            r  = int'($urandom_range(0, 19));
            op = (r < 18) ? 5'(r % 8) : 5'($urandom_range(8, 31));
            a  = pickVal();
            b  = pickVal();
            if (op == 5'd7 && $urandom_range(0, 5) == 0) b = 32'h0;
            sh = 5'($urandom_range(0, 31));
            issue(op, a, b, sh, 1, ae);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        randReady = 0;
        out_ready = 1;
        for (int n = 0; n < 200 && expQ.size() != 0; n++) @(posedge clock);
        #1;
        check("drain_queue_empty", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
